rst_seq_ctrl: RTL and testbench
===============================

# rst_seq_ctrl

Parametrised reset synchroniser and sequencer for the async FIFO subsystem and its neighbouring clock domains. It takes the chip-level asynchronous active-low reset, synchronises its deassertion through a configurable-depth flop chain, and releases NUM_OUT reset outputs one after another with a programmable gap between each. It optionally accepts a synchronous soft-reset request, which re-asserts all outputs with a minimum pulse width and then re-runs the release sequence. The DFT bypass lets ATPG drive every output directly from rst_n.

## Interface
- SYNC_STAGES, 2: synchroniser depth; must be ≥2.
- NUM_OUT, 4: number of sequenced reset outputs; must be ≥1.
- REL_DLY, 16: clk cycles between successive releases; must be ≥1.
- STRETCH, 8: minimum soft-reset assertion in clk cycles; must be ≥1.
- Illegal parameter values cause an elaboration error.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset: asynchronous, active-low.
- atpg_mode  input  1  test mode; 1 bypasses the synchroniser and sequencer.
- soft_rst_req  input  1  synchronous soft-reset request, level-sensitive. Present only with RST_SEQ_SOFT_RST_EN.
- rst_out_n  output  NUM_OUT  sequenced active-low resets; bit 0 is released first.
- seq_done  output  1  high once every output is released.

## Operation
- Synchroniser: a SYNC_STAGES-deep flop chain.
  - Cleared asynchronously by rst_n.
  - Shifts in 1 on every clk edge.
  - sync_n is the last stage.
- FSM states:
  - ASSERT: all outputs low. Leaves to WAIT when sync_n is sampled 1; the counter loads REL_DLY-1 on that transition.
  - WAIT: the counter decrements each edge. At 0 it releases the next bit (index idx), increments idx and reloads REL_DLY-1. After bit NUM_OUT-1 is released the FSM goes to DONE.
  - DONE: seq_done=1. The FSM stays here until reset or a soft request.
  - SOFT: present only with the macro; see Configuration.
- Counter width: $clog2(max(REL_DLY,STRETCH)+1). idx width: $clog2(NUM_OUT+1). No wrap is permitted: the counter only loads and decrements to 0.
- Outputs: rst_out_n bits and seq_done are registers, asynchronously reset by rst_n.
- Released bits stay high until rst_n or a soft reset.
- rst_n low at any time, including mid-sequence or mid-SOFT:
  - Immediately (asynchronously) rst_out_n=0 and seq_done=0.
  - Synchroniser, counter and idx are cleared; state is ASSERT.
- atpg_mode=1: every rst_out_n bit = rst_n and seq_done = rst_n, both combinationally. Internal flops still run normally.

## Timing
- Reset values: rst_out_n = {NUM_OUT{1'b0}}, seq_done = 0.
- Edge numbering: E0 is the first clk posedge with rst_n high after deassertion. sync_n is 1 after edge E(SYNC_STAGES-1).
- rst_out_n[i] rises at edge E(SYNC_STAGES-1 + (i+1)*REL_DLY).
- seq_done rises one edge after rst_out_n[NUM_OUT-1].
- Assertion is asynchronous, with zero-cycle latency from rst_n falling.
- Release is always synchronous to clk, and releases are monotonic in index order.
- A rst_n glitch shorter than one clk cycle still fully restarts the sequence.

## Configuration
- Macro: RST_SEQ_SOFT_RST_EN.
- Defined: the soft_rst_req port and SOFT state exist.
  - soft_rst_req sampled 1 at edge Q, from any state except ASSERT:
    - At Q all rst_out_n go low (synchronous assertion) and seq_done=0.
    - The state goes to SOFT and the counter loads STRETCH-1.
  - SOFT exits at edge R, the first edge at which the counter has reached 0 and soft_rst_req is sampled 0. R ≥ Q+STRETCH.
  - At R the FSM enters WAIT with the counter at REL_DLY-1 and idx=0. rst_out_n[i] then rises at R+(i+1)*REL_DLY.
  - A request arriving in SOFT extends it. A request in ASSERT is ignored.
  - A request during WAIT aborts the sequence, and already-released bits drop at Q.
- Undefined: no soft_rst_req port and no SOFT state. Only rst_n resets the outputs.

## Test plan
- SYNC_STAGES=2, NUM_OUT=4, REL_DLY=16; release rst_n before E0 -> rst_out_n bits rise at E17, E33, E49, E65; seq_done rises at E66.
- SYNC_STAGES=3, NUM_OUT=1, REL_DLY=1 -> rst_out_n[0] rises at E3; seq_done at E4.
- Drop rst_n asynchronously at E40 + half a cycle (default parameters) -> all outputs 0 within that half-cycle with no clk edge; after re-release the sequence restarts from E0 timing.
- Macro on, defaults, STRETCH=8: 1-cycle soft_rst_req sampled at Q in DONE -> outputs 0 and seq_done 0 at Q; rst_out_n[0] rises at Q+24, rst_out_n[3] at Q+72.
- Macro on: soft_rst_req held for 20 cycles from Q -> R=Q+20; rst_out_n[0] rises at Q+36. A request during ASSERT has no effect.
- atpg_mode=1: toggle rst_n with clk stopped -> every rst_out_n bit and seq_done follow rst_n combinationally.

Source files
------------

// File: rtl/rst_seq_ctrl.sv
// Reset synchroniser and sequencer: releases NUM_OUT active-low resets one after another, REL_DLY clocks apart.
// Optional synchronous soft reset is compiled in when RST_SEQ_SOFT_RST_EN is defined.
module rst_seq_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_OUT     = 4,
    parameter int REL_DLY     = 16,
    parameter int STRETCH     = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               atpg_mode,
`ifdef RST_SEQ_SOFT_RST_EN
    input  logic               soft_rst_req,
`endif
    output logic [NUM_OUT-1:0] rst_out_n,
    output logic               seq_done
);

    localparam int CNT_MAX = (REL_DLY > STRETCH) ? REL_DLY : STRETCH;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = $clog2(NUM_OUT + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] REL_LOAD  = CNT_W'(REL_DLY - 1);
    localparam logic [CNT_W-1:0] SOFT_LOAD = CNT_W'(STRETCH - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO  = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_OUT - 1);

    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("rst_seq_ctrl: SYNC_STAGES must be >= 2");
    end
    if (NUM_OUT < 1) begin : g_bad_num_out
        $error("rst_seq_ctrl: NUM_OUT must be >= 1");
    end
    if (REL_DLY < 1) begin : g_bad_rel_dly
        $error("rst_seq_ctrl: REL_DLY must be >= 1");
    end
    if (STRETCH < 1) begin : g_bad_stretch
        $error("rst_seq_ctrl: STRETCH must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_ASSERT = 2'd0,
        ST_WAIT   = 2'd1,
        ST_DONE   = 2'd2,
        ST_SOFT   = 2'd3
    } state_e;

    state_e                 state_q;
    state_e                 state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic [IDX_W-1:0]       idx_q;
    logic [IDX_W-1:0]       idx_d;
    logic [NUM_OUT-1:0]     rst_out_q;
    logic [NUM_OUT-1:0]     rst_out_d;
    logic                   seq_done_q;
    logic                   seq_done_d;

    logic sync_n_s;
    logic sync_pre_s;
    logic soft_req_s;
    logic soft_take_s;
    logic cnt_zero_s;
    logic release_s;

`ifdef RST_SEQ_SOFT_RST_EN
    assign soft_req_s = soft_rst_req;
`else
    assign soft_req_s = 1'b0;
`endif

    // The FSM leaves ASSERT on the same edge that sync_n rises, so it watches the stage feeding sync_n.
    assign sync_n_s    = sync_q[SYNC_STAGES-1];
    assign sync_pre_s  = sync_q[SYNC_STAGES-2];
    assign soft_take_s = soft_req_s && (state_q != ST_ASSERT);
    assign cnt_zero_s  = (cnt_q == CNT_ZERO);
    assign release_s   = cnt_zero_s && sync_n_s;

    // Synchroniser chain shift.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], 1'b1};
    end

    // Synchroniser flops, cleared asynchronously by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_q <= sync_d;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ASSERT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ASSERT: begin
                if (sync_pre_s) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_ASSERT;
                end
            end
            ST_WAIT: begin
                if (soft_take_s) begin
                    state_d = ST_SOFT;
                end else if (release_s && (idx_q == IDX_LAST)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DONE: begin
                if (soft_take_s) begin
                    state_d = ST_SOFT;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_SOFT: begin
                if (cnt_zero_s && !soft_req_s) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_SOFT;
                end
            end
            default: begin
                state_d = ST_ASSERT;
            end
        endcase
    end

    // FSM outputs: counter, release index and next values of the registered reset outputs.
    always_comb begin
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        rst_out_d  = rst_out_q;
        seq_done_d = 1'b0;
        case (state_q)
            ST_ASSERT: begin
                rst_out_d = {NUM_OUT{1'b0}};
                idx_d     = IDX_ZERO;
                if (sync_pre_s) begin
                    cnt_d = REL_LOAD;
                end else begin
                    cnt_d = CNT_ZERO;
                end
            end
            ST_WAIT: begin
                if (soft_take_s) begin
                    rst_out_d = {NUM_OUT{1'b0}};
                    idx_d     = IDX_ZERO;
                    cnt_d     = SOFT_LOAD;
                end else if (release_s) begin
                    for (int i = 0; i < NUM_OUT; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            rst_out_d[i] = 1'b1;
                        end else begin
                            rst_out_d[i] = rst_out_q[i];
                        end
                    end
                    idx_d = idx_q + IDX_ONE;
                    cnt_d = REL_LOAD;
                end else if (!cnt_zero_s) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_DONE: begin
                if (soft_take_s) begin
                    rst_out_d = {NUM_OUT{1'b0}};
                    idx_d     = IDX_ZERO;
                    cnt_d     = SOFT_LOAD;
                end else begin
                    seq_done_d = 1'b1;
                end
            end
            ST_SOFT: begin
                // A request held in SOFT only stalls the exit; the counter never reloads or wraps here.
                rst_out_d = {NUM_OUT{1'b0}};
                idx_d     = IDX_ZERO;
                if (!cnt_zero_s) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (!soft_req_s) begin
                    cnt_d = REL_LOAD;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                rst_out_d = {NUM_OUT{1'b0}};
                idx_d     = IDX_ZERO;
                cnt_d     = CNT_ZERO;
            end
        endcase
    end

    // Datapath and output registers, asynchronously asserted by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= CNT_ZERO;
            idx_q      <= IDX_ZERO;
            rst_out_q  <= {NUM_OUT{1'b0}};
            seq_done_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            rst_out_q  <= rst_out_d;
            seq_done_q <= seq_done_d;
        end
    end

    // ATPG lets the tester drive every reset straight from the pin.
    assign rst_out_n = atpg_mode ? {NUM_OUT{rst_n}} : rst_out_q;
    assign seq_done  = atpg_mode ? rst_n : seq_done_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl: default instance plus a SYNC_STAGES=3/NUM_OUT=1/REL_DLY=1 instance.
// Soft-reset sequences are exercised when RST_SEQ_SOFT_RST_EN is defined.
module tb_rst_seq_ctrl;

    logic       clk;
    logic       clk_en;
    logic       rst_n;
    logic       atpg_mode;
    logic       soft_rst_req;
    logic [3:0] rst_out_n;
    logic       seq_done;
    logic [0:0] rst_out2_n;
    logic       seq_done2;

    int n_checks;
    int n_fail;
    int edge_no;

    typedef struct {
        int         edge_no;
        logic [3:0] exp_out;
        logic       exp_done;
        logic       exp_out2;
        logic       exp_done2;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    rst_seq_ctrl #(.SYNC_STAGES(2), .NUM_OUT(4), .REL_DLY(16), .STRETCH(8)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .atpg_mode    (atpg_mode),
`ifdef RST_SEQ_SOFT_RST_EN
        .soft_rst_req (soft_rst_req),
`endif
        .rst_out_n    (rst_out_n),
        .seq_done     (seq_done)
    );

    rst_seq_ctrl #(.SYNC_STAGES(3), .NUM_OUT(1), .REL_DLY(1), .STRETCH(8)) u_dut2 (
        .clk          (clk),
        .rst_n        (rst_n),
        .atpg_mode    (atpg_mode),
`ifdef RST_SEQ_SOFT_RST_EN
        .soft_rst_req (soft_rst_req),
`endif
        .rst_out_n    (rst_out2_n),
        .seq_done     (seq_done2)
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] o, input logic d,
                             input logic o2, input logic d2);
        check({tag, " out"},   32'(rst_out_n),  32'(o));
        check({tag, " done"},  32'(seq_done),   32'(d));
        check({tag, " out2"},  32'(rst_out2_n), 32'(o2));
        check({tag, " done2"}, 32'(seq_done2),  32'(d2));
    endtask

    // Advance to edge n (counted from E0) and sample 1 time unit later.
    task automatic step_to(input int n);
        while (edge_no < n) begin
            @(posedge clk);
            edge_no++;
        end
        #1;
    endtask

    task automatic run_table(input string tag);
        for (int k = 0; k < NV; k++) begin
            step_to(vecs[k].edge_no);
            check_all($sformatf("%s E%0d", tag, vecs[k].edge_no), vecs[k].exp_out,
                      vecs[k].exp_done, vecs[k].exp_out2, vecs[k].exp_done2);
        end
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        clk_en       = 1'b1;
        rst_n        = 1'b0;
        atpg_mode    = 1'b0;
        soft_rst_req = 1'b0;

        vecs[0]  = '{0,  4'b0000, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{2,  4'b0000, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{3,  4'b0000, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{4,  4'b0000, 1'b0, 1'b1, 1'b1};
        vecs[4]  = '{16, 4'b0000, 1'b0, 1'b1, 1'b1};
        vecs[5]  = '{17, 4'b0001, 1'b0, 1'b1, 1'b1};
        vecs[6]  = '{32, 4'b0001, 1'b0, 1'b1, 1'b1};
        vecs[7]  = '{33, 4'b0011, 1'b0, 1'b1, 1'b1};
        vecs[8]  = '{48, 4'b0011, 1'b0, 1'b1, 1'b1};
        vecs[9]  = '{49, 4'b0111, 1'b0, 1'b1, 1'b1};
        vecs[10] = '{64, 4'b0111, 1'b0, 1'b1, 1'b1};
        vecs[11] = '{65, 4'b1111, 1'b0, 1'b1, 1'b1};
        vecs[12] = '{66, 4'b1111, 1'b1, 1'b1, 1'b1};
        vecs[13] = '{70, 4'b1111, 1'b1, 1'b1, 1'b1};

        // Reset state with clock running.
        repeat (3) @(posedge clk);
        #1;
        check_all("reset", 4'b0000, 1'b0, 1'b0, 1'b0);

        // First release, then an asynchronous glitch on rst_n half a cycle after E40.
        @(negedge clk);
        rst_n   = 1'b1;
        edge_no = -1;
        step_to(40);
        check_all("pre-glitch E40", 4'b0011, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all("async assert", 4'b0000, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n   = 1'b1;
        edge_no = -1;
        run_table("tbl");

`ifdef RST_SEQ_SOFT_RST_EN
        // One-cycle soft request sampled at Q=71 in DONE.
        @(negedge clk);
        soft_rst_req = 1'b1;
        step_to(71);
        check_all("soft Q", 4'b0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        soft_rst_req = 1'b0;
        step_to(79);
        check_all("soft Q+8", 4'b0000, 1'b0, 1'b0, 1'b0);
        step_to(80);
        check_all("soft Q+9", 4'b0000, 1'b0, 1'b1, 1'b0);
        step_to(94);
        check("soft Q+23 out", 32'(rst_out_n), 32'h0);
        step_to(95);
        check("soft Q+24 out", 32'(rst_out_n), 32'h1);
        step_to(142);
        check("soft Q+71 out", 32'(rst_out_n), 32'h7);
        step_to(143);
        check_all("soft Q+72", 4'b1111, 1'b0, 1'b1, 1'b1);
        step_to(144);
        check("soft Q+73 done", 32'(seq_done), 32'h1);

        // Request held 20 cycles from Q2=151: R=Q2+20.
        step_to(150);
        @(negedge clk);
        soft_rst_req = 1'b1;
        step_to(151);
        check_all("hold Q2", 4'b0000, 1'b0, 1'b0, 1'b0);
        step_to(170);
        @(negedge clk);
        soft_rst_req = 1'b0;
        step_to(171);
        check("hold Q2+20 out2", 32'(rst_out2_n), 32'h0);
        step_to(172);
        check("hold Q2+21 out2", 32'(rst_out2_n), 32'h1);
        step_to(186);
        check("hold Q2+35 out", 32'(rst_out_n), 32'h0);
        step_to(187);
        check("hold Q2+36 out", 32'(rst_out_n), 32'h1);

        // Request during WAIT drops the bit already released.
        @(negedge clk);
        soft_rst_req = 1'b1;
        step_to(188);
        check_all("abort Q3", 4'b0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        soft_rst_req = 1'b0;
`endif

        // ATPG bypass with the clock stopped low.
        @(negedge clk);
        clk_en = 1'b0;
        #2;
        atpg_mode = 1'b1;
        #1;
        check_all("atpg hi", 4'b1111, 1'b1, 1'b1, 1'b1);
        rst_n = 1'b0;
        #1;
        check_all("atpg lo", 4'b0000, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        #1;
        check_all("atpg hi2", 4'b1111, 1'b1, 1'b1, 1'b1);
        atpg_mode = 1'b0;
        #1;
        check_all("atpg off", 4'b0000, 1'b0, 1'b0, 1'b0);

        // Restart from E0; a soft request while still in ASSERT must be ignored.
        soft_rst_req = 1'b1;
        edge_no      = -1;
        clk_en       = 1'b1;
        step_to(1);
        @(negedge clk);
        soft_rst_req = 1'b0;
        step_to(3);
        check("assert-req E3 out2", 32'(rst_out2_n), 32'h1);
        step_to(16);
        check("assert-req E16 out", 32'(rst_out_n), 32'h0);
        step_to(17);
        check("assert-req E17 out", 32'(rst_out_n), 32'h1);
        step_to(66);
        check_all("assert-req E66", 4'b1111, 1'b1, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
